// File: rtl/ram_sweep_nxw_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_sweep_nxw_if
//  Brief    : Access bus for ram_sweep_nxw (request, read data, status flags).
//  Revision : 1.0
// ============================================================================
interface ram_sweep_nxw_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 4
);
    logic              en;
    logic              rw;
    logic [ADDR_W-1:0] endereco;
    logic [WIDTH-1:0]  inp;
    logic [WIDTH-1:0]  wmask;
    logic              init;
    logic [WIDTH-1:0]  y;
    logic              valid;
    logic              err;
    logic              busy;

    modport master (
        output en, rw, endereco, inp, wmask, init,
        input  y, valid, err, busy
    );

    modport slave (
        input  en, rw, endereco, inp, wmask, init,
        output y, valid, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/ram_sweep_nxw.sv
`default_nettype none
// ============================================================================
//  Module   : ram_sweep_nxw
//  Brief    : DEPTH x WIDTH single-port RAM with bit-masked writes, registered
//             reads, range/busy error pulses and a hardware zero-fill sweep.
//  Revision : 1.0
// ============================================================================
module ram_sweep_nxw #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic      clk,
    input  wire logic      clear,
    ram_sweep_nxw_if.slave bus
);
    localparam logic [0:0]        S_SWEEP = 1'b0;
    localparam logic [0:0]        S_IDLE  = 1'b1;
    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [0:0]        r_state, w_state_nx;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nx;
    logic [WIDTH-1:0]  r_y, w_y_nx;
    logic              r_valid, w_valid_nx;
    logic              r_err, w_err_nx;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WIDTH-1:0]  w_wdata;
    logic              w_in_range;
    logic [WIDTH-1:0]  w_rdata;

    // Non-power-of-two depths leave a hole at the top of the address space.
    assign w_in_range = ({1'b0, bus.endereco} < c_DEPTH);
    assign w_rdata    = w_in_range ? r_mem[bus.endereco] : '0;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_y_nx     = r_y;
        w_valid_nx = 1'b0;
        w_err_nx   = 1'b0;
        w_we       = 1'b0;
        w_waddr    = bus.endereco;
        w_wdata    = (w_rdata & ~bus.wmask) | (bus.inp & bus.wmask);
        case (r_state)
            S_SWEEP: begin
                w_we     = 1'b1;
                w_waddr  = r_cnt;
                w_wdata  = '0;
                w_err_nx = bus.en;
                if (r_cnt == c_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + ADDR_W'(1);
                end
            end
            S_IDLE: begin
                if (bus.init) begin
                    // A simultaneous access loses to init and is reported.
                    w_state_nx = S_SWEEP;
                    w_err_nx   = bus.en;
                end else if (bus.en) begin
                    if (!w_in_range) begin
                        w_err_nx = 1'b1;
                        if (!bus.rw) begin
                            w_y_nx     = '0;
                            w_valid_nx = 1'b1;
                        end
                    end else if (bus.rw) begin
                        w_we = 1'b1;
                    end else begin
                        w_y_nx     = w_rdata;
                        w_valid_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_SWEEP;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= S_SWEEP;
            r_cnt   <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_y     <= w_y_nx;
            r_valid <= w_valid_nx;
            r_err   <= w_err_nx;
        end
    end

    // Storage has no reset; writes are held off while clear is asserted.
    always_ff @(posedge clk) begin
        if (clear && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign bus.y     = r_y;
    assign bus.valid = r_valid;
    assign bus.err   = r_err;
    assign bus.busy  = (r_state == S_SWEEP);
endmodule
`default_nettype wire

// File: tb/tb_ram_sweep_nxw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_sweep_nxw
//  Brief    : Scoreboard bench driving a DEPTH=16 and a DEPTH=12 instance with
//             the same directed and random traffic against a word-array model.
//  Revision : 1.0
// ============================================================================
module tb_ram_sweep_nxw;
    localparam int W  = 4;
    localparam int AW = 4;

    typedef struct {
        logic [W-1:0] y;
        logic         v;
        logic         e;
    } exp_t;

    logic clk = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    ram_sweep_nxw_if #(.WIDTH(W), .ADDR_W(AW)) ifa ();
    ram_sweep_nxw_if #(.WIDTH(W), .ADDR_W(AW)) ifb ();

    assign ifb.en       = ifa.en;
    assign ifb.rw       = ifa.rw;
    assign ifb.endereco = ifa.endereco;
    assign ifb.inp      = ifa.inp;
    assign ifb.wmask    = ifa.wmask;
    assign ifb.init     = ifa.init;

    ram_sweep_nxw #(.WIDTH(W), .DEPTH(16), .ADDR_W(AW)) u_dut_a (
        .clk   (clk),
        .clear (clear),
        .bus   (ifa.slave)
    );

    ram_sweep_nxw #(.WIDTH(W), .DEPTH(12), .ADDR_W(AW)) u_dut_b (
        .clk   (clk),
        .clear (clear),
        .bus   (ifb.slave)
    );

    int           checks   = 0;
    int           failures = 0;
    int           depth [2] = '{16, 12};
    int           sweep_left [2];
    logic [W-1:0] mdl [2][16];
    logic [W-1:0] last_y [2];
    exp_t         q_a [$];
    exp_t         q_b [$];

    function automatic void push(input int k, input logic [W-1:0] y, input logic v, input logic e);
        exp_t x;
        x.y = y;
        x.v = v;
        x.e = e;
        if (k == 0) q_a.push_back(x);
        else        q_b.push_back(x);
    endfunction

    // Reference: one call per rising edge, describing what that edge does.
    task automatic predict(input int k, input logic en, input logic rw, input int addr,
                           input logic [W-1:0] d, input logic [W-1:0] mk, input logic ini);
        if (sweep_left[k] > 0) begin
            if (en) push(k, '0, 1'b0, 1'b1);
            mdl[k][depth[k] - sweep_left[k]] = '0;
            sweep_left[k]--;
        end else if (ini) begin
            if (en) push(k, '0, 1'b0, 1'b1);
            sweep_left[k] = depth[k];
        end else if (en) begin
            if (addr >= depth[k])  push(k, '0, !rw, 1'b1);
            else if (rw)           mdl[k][addr] = (mdl[k][addr] & ~mk) | (d & mk);
            else                   push(k, mdl[k][addr], 1'b1, 1'b0);
        end
    endtask

    task automatic check_out(input int k, input logic [W-1:0] y, input logic v, input logic e);
        exp_t x;
        checks++;
        if (!clear) begin
            if (y !== '0 || v !== 1'b0 || e !== 1'b0) begin
                failures++;
                $display("FAIL reset_out dut=%0d got y=%h v=%b e=%b need y=0 v=0 e=0", k, y, v, e);
            end
            last_y[k] = '0;
            return;
        end
        if (v === 1'b1 || e === 1'b1) begin
            if ((k == 0 ? q_a.size() : q_b.size()) == 0) begin
                failures++;
                $display("FAIL unexpected_out dut=%0d got y=%h v=%b e=%b need no output", k, y, v, e);
            end else begin
                x = (k == 0) ? q_a.pop_front() : q_b.pop_front();
                if (v !== x.v || e !== x.e || (x.v && y !== x.y)) begin
                    failures++;
                    $display("FAIL response dut=%0d got y=%h v=%b e=%b need y=%h v=%b e=%b",
                             k, y, v, e, x.y, x.v, x.e);
                end
            end
        end else if (y !== last_y[k]) begin
            failures++;
            $display("FAIL y_hold dut=%0d got y=%h need y=%h", k, y, last_y[k]);
        end
        last_y[k] = y;
    endtask

    always @(posedge clk) begin
        #1;
        check_out(0, ifa.y, ifa.valid, ifa.err);
        check_out(1, ifb.y, ifb.valid, ifb.err);
    end

    task automatic check_busy();
        checks += 2;
        if (ifa.busy !== (sweep_left[0] > 0)) begin
            failures++;
            $display("FAIL busy dut=0 got %b need %b", ifa.busy, sweep_left[0] > 0);
        end
        if (ifb.busy !== (sweep_left[1] > 0)) begin
            failures++;
            $display("FAIL busy dut=1 got %b need %b", ifb.busy, sweep_left[1] > 0);
        end
    endtask

    task automatic drive(input logic en, input logic rw, input int addr,
                         input logic [W-1:0] d, input logic [W-1:0] mk, input logic ini);
        ifa.en       = en;
        ifa.rw       = rw;
        ifa.endereco = addr[AW-1:0];
        ifa.inp      = d;
        ifa.wmask    = mk;
        ifa.init     = ini;
    endtask

    task automatic do_cycle(input logic en, input logic rw, input int addr,
                            input logic [W-1:0] d, input logic [W-1:0] mk, input logic ini);
        @(negedge clk);
        check_busy();
        drive(en, rw, addr, d, mk, ini);
        for (int k = 0; k < 2; k++) predict(k, en, rw, addr, d, mk, ini);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 0, '0, '0, 1'b0);
    endtask

    // Asserts clear for n cycles; the release edge starts the model's sweep.
    task automatic apply_reset(input int n);
        @(negedge clk);
        clear = 1'b0;
        drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
        for (int k = 0; k < 2; k++) sweep_left[k] = depth[k];
        #1;
        check_busy();
        repeat (n) @(negedge clk);
        check_busy();
        clear = 1'b1;
        for (int k = 0; k < 2; k++) predict(k, 1'b0, 1'b0, 0, '0, '0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            sweep_left[k] = depth[k];
            last_y[k]     = '0;
            for (int a = 0; a < 16; a++) mdl[k][a] = '0;
        end
        drive(1'b0, 1'b0, 0, '0, '0, 1'b0);

        apply_reset(2);
        do_cycle(1'b1, 1'b1, 2, 4'hF, 4'hF, 1'b0);
        idle(16);
        do_cycle(1'b1, 1'b0, 5, '0, '0, 1'b0);
        do_cycle(1'b1, 1'b0, 2, '0, '0, 1'b0);
        do_cycle(1'b1, 1'b1, 3, 4'b1101, 4'b1111, 1'b0);
        do_cycle(1'b1, 1'b0, 3, '0, '0, 1'b0);
        idle(3);
        do_cycle(1'b1, 1'b1, 3, 4'b0010, 4'b0011, 1'b0);
        do_cycle(1'b1, 1'b0, 3, '0, '0, 1'b0);
        do_cycle(1'b1, 1'b1, 7, 4'hF, 4'h0, 1'b0);
        do_cycle(1'b1, 1'b0, 7, '0, '0, 1'b0);
        do_cycle(1'b1, 1'b1, 9, 4'b1010, 4'hF, 1'b0);
        do_cycle(1'b1, 1'b0, 9, '0, '0, 1'b1);
        idle(17);
        do_cycle(1'b1, 1'b0, 9, '0, '0, 1'b0);
        do_cycle(1'b1, 1'b1, 13, 4'h5, 4'hF, 1'b0);
        for (int a = 0; a < 16; a++) do_cycle(1'b1, 1'b0, a, '0, '0, 1'b0);

        do_cycle(1'b0, 1'b0, 0, '0, '0, 1'b1);
        idle(6);
        apply_reset(3);
        idle(17);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                apply_reset(int'($urandom_range(1, 3)));
            end else begin
                do_cycle($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                         int'($urandom_range(0, 15)), W'($urandom),
                         ($urandom_range(0, 2) == 0) ? 4'hF : W'($urandom),
                         $urandom_range(0, 99) < 2);
            end
        end

        idle(3);
        @(posedge clk);
        #2;
        checks += 2;
        if (q_a.size() != 0) begin
            failures++;
            $display("FAIL pending_dut0 got %0d outstanding need 0", q_a.size());
        end
        if (q_b.size() != 0) begin
            failures++;
            $display("FAIL pending_dut1 got %0d outstanding need 0", q_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ram_sweep_nxw.md
Name: ram_sweep_nxw

Overview:
- Parametrised single-port synchronous RAM; successor to the 1x4 JK-cell RAM slice: DEPTH words of WIDTH bits.
- Adds per-bit write mask, registered read with valid flag, and out-of-range and busy error reporting.
- Adds a hardware zero-fill sweep: automatic after reset and re-triggerable by `init`.
- Used as the generic storage element for the datapath exercises.

Parameters:
WIDTH, 4, bits per word
DEPTH, 16, number of words (need not be a power of two)
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  input  1  clock; all state changes on rising edge except reset
clear  input  1  asynchronous reset, active-low (0 = reset)
en  input  1  access request strobe
rw  input  1  1 = write, 0 = read (sampled with en)
endereco  input  ADDR_W  word address
inp  input  WIDTH  write data
wmask  input  WIDTH  per-bit write enable (1 = bit written)
init  input  1  request zero-fill sweep
y  output  WIDTH  registered read data
valid  output  1  y updated this cycle (one-cycle pulse per read)
err  output  1  one-cycle pulse: request rejected
busy  output  1  sweep in progress; accesses rejected

Behaviour:
- Reset (clear=0, asynchronous):
  - y=0, valid=0, err=0, busy=1.
  - FSM forced to SWEEP with sweep counter=0. Memory contents are not reset asynchronously.
- FSM states: SWEEP, IDLE.
- SWEEP:
  - Each rising edge writes 0 to mem[counter] and increments counter.
  - On the edge that writes word DEPTH-1: counter wraps to 0, FSM goes to IDLE, busy falls to 0.
  - busy is high for exactly DEPTH clock edges after clear is released.
- IDLE transitions:
  - init=1 -> SWEEP. busy=1 from the next cycle; sweep begins at word 0.
  - If en=1 in the same cycle as init, init wins: access dropped, err=1 next cycle.
- Write (IDLE, en=1, rw=1, endereco<DEPTH):
  - mem[endereco] <= (mem[endereco] & ~wmask) | (inp & wmask).
  - valid stays 0; y holds its value.
- Read (IDLE, en=1, rw=0, endereco<DEPTH):
  - y <= mem[endereco] at that edge; valid=1 for exactly that one cycle.
  - Latency: 1 edge from request to data.
  - Read on the cycle after a write to the same address returns the new data.
- Out of range (endereco>=DEPTH):
  - Write is dropped and memory is unchanged.
  - Read sets y<=0 with valid=1.
  - err=1 for one cycle in both cases.
- Access while busy=1 (en=1): dropped, err=1 for one cycle, valid=0, y holds. init while busy is ignored, with no err.
- valid and err default to 0 on every edge unless set by the rules above. Back-to-back reads give a continuous valid train.
- Reset mid-sweep: counter returns to 0; the full sweep restarts after release.
- Reset mid-access: the access is lost; outputs take their reset values.
- wmask=0 write: a legal no-op; err=0.

Test Plan (WIDTH=4, DEPTH=16 unless noted):
- Release clear -> busy=1 for exactly 16 edges, then 0. Read addr 5 -> y=0000 with valid=1 one edge after the request.
- Write addr 3, inp=1101, wmask=1111; then read addr 3 on the next cycle -> y=1101 with valid=1; y holds while idle with valid=0.
- Write addr 3, inp=0010, wmask=0011 over stored 1101 -> a read returns 1110. Write addr 7 with wmask=0000 -> a read returns 0000, err=0.
- During the post-reset sweep, issue a write to addr 2 -> err pulses once. After busy=0, reading addr 2 returns 0000.
- Write addr 9 = 1010, then assert init together with en (read addr 9) -> err=1, busy=1 for 16 cycles. After that, reading addr 9 -> y=0000.
- DEPTH=12, ADDR_W=4: write addr 13 -> err=1 and no word changes. Read addr 13 -> y=0000, valid=1, err=1.
- Pull clear low at sweep counter=6 and release -> busy=1 for a full 16 edges again; y=0 and valid=0 while clear is low.
